rr_arb4: RTL and testbench

RR_ARB4 -- requirements
Module: rr_arb4

---
 rtl/rr_arb_pkg.sv | 17 +
 rtl/onhot_enc4.sv | 17 +
 rtl/rr_arb4.sv | 109 ++++++++++
 tb/tb_rr_arb4.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and defaults for the 4-way round-robin arbiter.
// Holds the FSM encoding, the search result type and the default hold limit.
package rr_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } pick_t;

  localparam int HOLD_MAX_DEF = 8;

endpackage

// File: rtl/onhot_enc4.sv
// One-hot to binary index encoder for a 4-bit vector; all-zero encodes as 0.
module onhot_enc4 (
  input  logic [3:0] onehot,
  output logic [1:0] idx
);

  always_comb begin
    idx = 2'd0;
    case (onehot)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with registered one-hot grant and
// hold-time preemption once a holder has kept the grant for HOLD_MAX cycles.
module rr_arb4
  import rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy
);

  localparam int HOLD_EFF = (HOLD_MAX < 2) ? 2 : HOLD_MAX;
  localparam int CW       = $clog2(HOLD_EFF);
  localparam logic [CW-1:0] HCNT_LIM = CW'(HOLD_EFF - 1);

  state_t        state, state_n;
  logic [1:0]    ptr, ptr_n;
  logic [CW-1:0] hcnt, hcnt_n;
  logic [3:0]    gnt_n;
  pick_t         pick_all, pick_oth;
  logic          holder_req, at_limit;

  // First asserted bit of r scanning p, p+1, p+2, p+3 (mod 4).
  function automatic pick_t rr_pick(input logic [3:0] r, input logic [1:0] p);
    pick_t      res;
    logic [1:0] idx;
    res = '0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!res.vld && r[idx]) begin
        res.vld = 1'b1;
        res.idx = idx;
      end
    end
    return res;
  endfunction

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    hcnt_n     = hcnt;
    gnt_n      = gnt;
    pick_all   = rr_pick(req, ptr);
    pick_oth   = rr_pick(req & ~gnt, ptr);
    holder_req = |(req & gnt);
    at_limit   = (hcnt == HCNT_LIM);
    case (state)
      ST_IDLE: begin
        if (pick_all.vld) begin
          state_n = ST_GRANT;
          gnt_n   = 4'b0001 << pick_all.idx;
          ptr_n   = pick_all.idx + 2'd1;
          hcnt_n  = '0;
        end
      end
      ST_GRANT: begin
        // A release wins over a simultaneous preemption condition.
        if (!holder_req) begin
          if (pick_all.vld) begin
            gnt_n  = 4'b0001 << pick_all.idx;
            ptr_n  = pick_all.idx + 2'd1;
            hcnt_n = '0;
          end else begin
            state_n = ST_IDLE;
            gnt_n   = 4'b0000;
            hcnt_n  = '0;
          end
        end else if (at_limit && pick_oth.vld) begin
          gnt_n  = 4'b0001 << pick_oth.idx;
          ptr_n  = pick_oth.idx + 2'd1;
          hcnt_n = '0;
        end else if (!at_limit) begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = 4'b0000;
        hcnt_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= 2'd0;
      hcnt  <= '0;
      gnt   <= 4'b0000;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      hcnt  <= hcnt_n;
      gnt   <= gnt_n;
    end
  end

  onhot_enc4 u_enc (
    .onehot (gnt),
    .idx    (gnt_id)
  );

  assign busy = |gnt;

endmodule

// File: tb/tb_rr_arb4.sv
// Directed and randomized bench for rr_arb4 against an integer-level
// round-robin reference model with hold-time preemption.
module tb_rr_arb4;

  localparam int HM    = 8;
  localparam int WBND  = 3 * HM + 3;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;

  int vectors;
  int miscompares;

  // Reference model state: holder index (-1 = none), pointer, cycles held.
  int m_hold;
  int m_ptr;
  int m_cnt;
  int waitc [4];

  rr_arb4 #(.HOLD_MAX(HM)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_hold = -1;
    m_ptr  = 0;
    m_cnt  = 0;
    for (int i = 0; i < 4; i++) waitc[i] = 0;
  endtask

  task automatic new_grant(input int i);
    m_hold = i;
    m_ptr  = (i + 1) % 4;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int i;
    logic [3:0] others;
    if (m_hold < 0) begin
      i = pick(r, m_ptr);
      if (i >= 0) new_grant(i);
    end else if (!r[m_hold]) begin
      i = pick(r, m_ptr);
      if (i >= 0) new_grant(i);
      else m_hold = -1;
    end else begin
      others = r & ~(4'b0001 << m_hold);
      if (m_cnt == HM - 1 && others != 4'b0000) new_grant(pick(others, m_ptr));
      else if (m_cnt < HM - 1) m_cnt++;
    end
  endtask

  function automatic logic [3:0] exp_gnt();
    return (m_hold < 0) ? 4'b0000 : (4'b0001 << m_hold);
  endfunction

  // One clock edge: advance the model with the applied req, then check outputs.
  task automatic tick();
    logic [3:0] r;
    logic [1:0] eid;
    r = req;
    model_step(r);
    @(posedge clk);
    #1;
    eid = (m_hold < 0) ? 2'd0 : 2'(m_hold);
    chk("gnt", 32'(gnt), 32'(exp_gnt()));
    chk("gnt_id", 32'(gnt_id), 32'(eid));
    chk("busy", 32'(busy), 32'(|exp_gnt()));
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("gnt_without_req", 32'(gnt & ~r), 32'd0);
    for (int i = 0; i < 4; i++) begin
      waitc[i] = (r[i] && !gnt[i]) ? waitc[i] + 1 : 0;
      chk("wait_bound", 32'(waitc[i] > WBND), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] prev;
    int run;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    req = 4'b0000;
    model_reset();
    #1;
    do_reset();

    // Idle with no requests.
    tick();
    tick();

    // Scenario 1 and 2: first grant from PTR=0, then direct handover.
    req = 4'b0101;
    tick();
    chk("s1_gnt", 32'(gnt), 32'h1);
    req = 4'b0100;
    tick();
    chk("s2_gnt", 32'(gnt), 32'h4);
    chk("s2_id", 32'(gnt_id), 32'h2);
    req = 4'b0000;
    tick();
    chk("release_idle", 32'(busy), 32'd0);

    // Scenario 3: all requesting, every grant held exactly HM cycles.
    do_reset();
    req  = 4'b1111;
    tick();
    chk("s3_first", 32'(gnt), 32'h1);
    prev = gnt;
    run  = 1;
    for (int c = 0; c < 5 * HM; c++) begin
      tick();
      if (gnt != prev) begin
        chk("s3_run", 32'(run), 32'(HM));
        chk("s3_rotate", 32'(gnt), 32'(prev[3] ? 4'b0001 : (prev << 1)));
        prev = gnt;
        run  = 1;
      end else begin
        run++;
      end
    end

    // Scenario 4: lone requester is never preempted.
    do_reset();
    req = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("s4_hold", 32'(gnt), 32'h8);
    end
    req = 4'b0000;
    tick();
    chk("s4_drop", 32'(gnt), 32'h0);
    chk("s4_busy", 32'(busy), 32'h0);

    // Scenario 5: asynchronous reset mid-grant, then PTR=0 search.
    req = 4'b0010;
    tick();
    chk("s5_pre", 32'(gnt), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("s5_async", 32'(gnt), 32'h0);
    chk("s5_async_busy", 32'(busy), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1010;
    tick();
    chk("s5_after", 32'(gnt), 32'h2);

    // Scenario 6: randomized requests with sticky bits.
    do_reset();
    req = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
